sr_ff_bank: RTL and testbench

- Parametrised, clocked successor to the team's NAND SR latch: CH independent set/reset storage cells with guaranteed complementary outputs.
- Each channel has a per-channel input stability filter and a configurable resolution mode for the S=R=1 case, so the forbidden state is defined instead of undefined.
- A saturating counter and a sticky flag track S=R=1 events for diagnostics.
- Sits between raw control or status inputs (buttons, handshake strobes) and downstream logic that needs clean, held flags.

---
 rtl/sr_ff_bank.sv | 113 +++++++++++
 tb/tb_sr_ff_bank.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of CH filtered set/reset flags with defined S=R=1 resolution and 11-event diagnostics.
// Latency: a stable raw pair reaches q DEB+1 edges after first sampling; no backpressure, inputs are levels.
module sr_ff_bank #(
   parameter int CH   = 4,
   parameter int MODE = 0,
   parameter int DEB  = 2,
   parameter int ERRW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH-1:0]   s,
   input  logic [CH-1:0]   r,
   input  logic            en,
   input  logic            clr_err,
   output logic [CH-1:0]   q,
   output logic [CH-1:0]   qbar,
   output logic [CH-1:0]   both_evt,
   output logic [ERRW-1:0] err_cnt,
   output logic            err_sticky
);

   localparam int CW = (DEB < 1) ? 1 : $clog2(DEB + 1);
   localparam logic [CW-1:0] DEB_C = CW'(DEB);
   localparam int SW = ERRW + 7;

   logic [CH-1:0]   smp_s_q, smp_s_d, smp_r_q, smp_r_d;
   logic [CH-1:0]   flt_s_q, flt_s_d, flt_r_q, flt_r_d;
   logic [CW-1:0]   cnt_q [CH];
   logic [CW-1:0]   cnt_d [CH];
   logic [CH-1:0]   q_q, q_d, qbar_q, qbar_d, both_q, both_d;
   logic [ERRW-1:0] err_q, err_d;
   logic            sticky_q, sticky_d;
   logic [CH-1:0]   entry;
   logic [6:0]      ent_n;
   logic [SW-1:0]   err_sum;

   always_comb begin
      smp_s_d  = s;
      smp_r_d  = r;
      flt_s_d  = flt_s_q;
      flt_r_d  = flt_r_q;
      q_d      = q_q;
      both_d   = '0;
      entry    = '0;
      ent_n    = '0;
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = '0;
         if ({s[i], r[i]} == {smp_s_q[i], smp_r_q[i]}) begin
            cnt_d[i] = (cnt_q[i] == DEB_C) ? cnt_q[i] : cnt_q[i] + CW'(1);
         end
         // The filter accepts on the edge where the new count reaches DEB.
         if (cnt_d[i] == DEB_C) begin
            flt_s_d[i] = s[i];
            flt_r_d[i] = r[i];
         end
         both_d[i] = flt_s_d[i] & flt_r_d[i];
         entry[i]  = both_d[i] & ~both_q[i];
         ent_n     = ent_n + 7'(entry[i]);
         if (en) begin
            case ({flt_s_q[i], flt_r_q[i]})
               2'b10:   q_d[i] = 1'b1;
               2'b01:   q_d[i] = 1'b0;
               2'b11: begin
                  if (MODE == 0)      q_d[i] = 1'b0;
                  else if (MODE == 1) q_d[i] = 1'b1;
                  else if (MODE == 3) q_d[i] = ~q_q[i];
                  else                q_d[i] = q_q[i];
               end
               default: q_d[i] = q_q[i];
            endcase
         end
      end
      qbar_d = ~q_d;
      // A clear never discards events entering in the same cycle.
      err_sum = (clr_err ? '0 : SW'(err_q)) + SW'(ent_n);
      if (err_sum > SW'({ERRW{1'b1}})) err_d = '1;
      else                             err_d = err_sum[ERRW-1:0];
      sticky_d = (|entry) | (sticky_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_s_q  <= '0;
         smp_r_q  <= '0;
         flt_s_q  <= '0;
         flt_r_q  <= '0;
         for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
         q_q      <= '0;
         qbar_q   <= '1;
         both_q   <= '0;
         err_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         smp_s_q  <= smp_s_d;
         smp_r_q  <= smp_r_d;
         flt_s_q  <= flt_s_d;
         flt_r_q  <= flt_r_d;
         for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
         q_q      <= q_d;
         qbar_q   <= qbar_d;
         both_q   <= both_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   assign q          = q_q;
   assign qbar       = qbar_q;
   assign both_evt   = both_q;
   assign err_cnt    = err_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four DEB=2 instances (MODE 0..3, ERRW=2) and one DEB=0 MODE=3 ERRW=8 instance.
module tb_sr_ff_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] s_i, r_i;
   logic       en_i, clr_i;
   logic [3:0] q_o [5];
   logic [3:0] qb_o [5];
   logic [3:0] be_o [5];
   logic       st_o [5];
   logic [1:0] e2_o [4];
   logic [7:0] e8_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_mode
         sr_ff_bank #(.CH(4), .MODE(g), .DEB(2), .ERRW(2)) u_dut (
            .clk(clk), .rst_n(rst_n), .s(s_i), .r(r_i), .en(en_i), .clr_err(clr_i),
            .q(q_o[g]), .qbar(qb_o[g]), .both_evt(be_o[g]), .err_cnt(e2_o[g]), .err_sticky(st_o[g]));
      end
   endgenerate

   sr_ff_bank #(.CH(4), .MODE(3), .DEB(0), .ERRW(8)) u_deb0 (
      .clk(clk), .rst_n(rst_n), .s(s_i), .r(r_i), .en(en_i), .clr_err(clr_i),
      .q(q_o[4]), .qbar(qb_o[4]), .both_evt(be_o[4]), .err_cnt(e8_o), .err_sticky(st_o[4]));

   // Reference model: raw input history plus per-instance flag state.
   logic [3:0] hs [$];
   logic [3:0] hr [$];
   logic [3:0] mq [5];
   logic [1:0] mf [5][4];
   int         merr [5];
   bit         mst [5];

   function automatic int deb_of(int i);  return (i == 4) ? 0 : 2;   endfunction
   function automatic int mode_of(int i); return (i == 4) ? 3 : i;   endfunction
   function automatic int max_of(int i);  return (i == 4) ? 255 : 3; endfunction

   // {accepted, pair}: accepted when the last d+1 samples of this channel agree.
   function automatic logic [2:0] stable_pair(int ch, int d);
      int n;
      logic [1:0] p;
      n = hs.size();
      p = {hs[n-1][ch], hr[n-1][ch]};
      if (n < d + 1) return {1'b0, p};
      for (int k = 1; k <= d; k++)
         if ({hs[n-1-k][ch], hr[n-1-k][ch]} != p) return {1'b0, p};
      return {1'b1, p};
   endfunction

   task automatic model_reset();
      hs.delete(); hr.delete();
      hs.push_back(4'h0); hr.push_back(4'h0);
      for (int i = 0; i < 5; i++) begin
         mq[i] = 4'h0; merr[i] = 0; mst[i] = 1'b0;
         for (int c = 0; c < 4; c++) mf[i][c] = 2'b00;
      end
   endtask

   task automatic model_edge();
      logic [2:0] sp;
      logic [1:0] np;
      int ent, base;
      hs.push_back(s_i); hr.push_back(r_i);
      if (hs.size() > 8) begin void'(hs.pop_front()); void'(hr.pop_front()); end
      for (int i = 0; i < 5; i++) begin
         ent = 0;
         for (int c = 0; c < 4; c++) begin
            sp = stable_pair(c, deb_of(i));
            np = sp[2] ? sp[1:0] : mf[i][c];
            if (en_i) begin
               if (mf[i][c] == 2'b10) mq[i][c] = 1'b1;
               else if (mf[i][c] == 2'b01) mq[i][c] = 1'b0;
               else if (mf[i][c] == 2'b11) begin
                  case (mode_of(i))
                     0: mq[i][c] = 1'b0;
                     1: mq[i][c] = 1'b1;
                     3: mq[i][c] = ~mq[i][c];
                     default: ;
                  endcase
               end
            end
            if (np == 2'b11 && mf[i][c] != 2'b11) ent++;
            mf[i][c] = np;
         end
         base = clr_i ? 0 : merr[i];
         merr[i] = (base + ent > max_of(i)) ? max_of(i) : base + ent;
         mst[i]  = (ent > 0) || (mst[i] && !clr_i);
      end
   endtask

   task automatic step(input logic [3:0] s, input logic [3:0] r, input logic e, input logic c);
      s_i = s; r_i = r; en_i = e; clr_i = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; s_i = '0; r_i = '0; en_i = 1'b1; clr_i = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (q_o[i] !== 4'h0 || qb_o[i] !== 4'hF || be_o[i] !== 4'h0 || st_o[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset inst%0d: q=%h qbar=%h both=%h sticky=%b, want 0 f 0 0", i, q_o[i], qb_o[i], be_o[i], st_o[i]);
         end
      end
      total++;
      if (e2_o[0] !== 2'd0 || e8_o !== 8'd0) begin
         bad++; $display("FAIL reset_err: err=%0d/%0d want 0/0", e2_o[0], e8_o);
      end
   endtask

   task automatic test_latency();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(4'b0001, 4'b0000, 1'b1, 1'b0);
         total++;
         if (q_o[0] !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
            bad++; $display("FAIL latency edge%0d: q=%b want %b", k, q_o[0], (k == 3) ? 4'b0001 : 4'b0000);
         end
         total++;
         if (q_o[4] !== ((k >= 1) ? 4'b0001 : 4'b0000)) begin
            bad++; $display("FAIL latency_deb0 edge%0d: q=%b", k, q_o[4]);
         end
      end
      total++;
      if (qb_o[0] !== 4'b1110) begin bad++; $display("FAIL latency_qbar: qbar=%b want 1110", qb_o[0]); end
   endtask

   task automatic test_glitch();
      do_reset();
      repeat (2) step(4'b0010, 4'b0000, 1'b1, 1'b0);
      repeat (4) step(4'b0000, 4'b0000, 1'b1, 1'b0);
      total++;
      if (q_o[0] !== 4'b0000) begin bad++; $display("FAIL glitch_short: q=%b want 0000", q_o[0]); end
      repeat (3) step(4'b0010, 4'b0000, 1'b1, 1'b0);
      total++;
      if (q_o[0] !== 4'b0000) begin bad++; $display("FAIL glitch_early: q=%b want 0000", q_o[0]); end
      step(4'b0000, 4'b0000, 1'b1, 1'b0);
      total++;
      if (q_o[0] !== 4'b0010) begin bad++; $display("FAIL glitch_held: q=%b want 0010", q_o[0]); end
   endtask

   task automatic test_modes();
      logic exp_q;
      do_reset();
      repeat (4) step(4'b0001, 4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (q_o[i][0] !== 1'b1) begin bad++; $display("FAIL modes_start inst%0d: q0=%b want 1", i, q_o[i][0]); end
      end
      for (int k = 0; k < 7; k++) begin
         step(4'b0001, 4'b0001, 1'b1, 1'b0);
         if (k >= 3) begin
            for (int i = 0; i < 5; i++) begin
               if (i == 0)      exp_q = 1'b0;
               else if (i < 3)  exp_q = 1'b1;
               else             exp_q = (k % 2 == 1) ? 1'b0 : 1'b1;
               total++;
               if (q_o[i][0] !== exp_q || qb_o[i][0] !== ~exp_q) begin
                  bad++; $display("FAIL modes inst%0d edge%0d: q0=%b qbar0=%b want q0=%b", i, k, q_o[i][0], qb_o[i][0], exp_q);
               end
            end
         end
      end
      total++;
      if (be_o[0] !== 4'b0001) begin bad++; $display("FAIL modes_both: both=%b want 0001", be_o[0]); end
   endtask

   task automatic test_errors();
      do_reset();
      step(4'b0111, 4'b0111, 1'b1, 1'b0);
      step(4'b0111, 4'b0111, 1'b1, 1'b0);
      total++;
      if (e2_o[0] !== 2'd0) begin bad++; $display("FAIL err_early: err=%0d want 0", e2_o[0]); end
      step(4'b0111, 4'b0111, 1'b1, 1'b0);
      total++;
      if (e2_o[0] !== 2'd3 || st_o[0] !== 1'b1) begin
         bad++; $display("FAIL err_three: err=%0d sticky=%b want 3 1", e2_o[0], st_o[0]);
      end
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);
      repeat (3) step(4'b1000, 4'b1000, 1'b1, 1'b0);
      total++;
      if (e2_o[0] !== 2'd3) begin bad++; $display("FAIL err_sat: err=%0d want 3", e2_o[0]); end
      repeat (2) step(4'b1001, 4'b1001, 1'b1, 1'b0);
      step(4'b1001, 4'b1001, 1'b1, 1'b1);
      total++;
      if (e2_o[0] !== 2'd1 || st_o[0] !== 1'b1) begin
         bad++; $display("FAIL err_clr_entry: err=%0d sticky=%b want 1 1", e2_o[0], st_o[0]);
      end
      step(4'b1001, 4'b1001, 1'b1, 1'b1);
      total++;
      if (e2_o[0] !== 2'd0 || st_o[0] !== 1'b0) begin
         bad++; $display("FAIL err_clr: err=%0d sticky=%b want 0 0", e2_o[0], st_o[0]);
      end
   endtask

   task automatic test_enable();
      do_reset();
      repeat (3) step(4'b0011, 4'b0011, 1'b0, 1'b0);
      total++;
      if (be_o[0] !== 4'b0011 || q_o[0] !== 4'b0000) begin
         bad++; $display("FAIL en_both: both=%b q=%b want 0011 0000", be_o[0], q_o[0]);
      end
      repeat (3) step(4'b1111, 4'b0000, 1'b0, 1'b0);
      total++;
      if (q_o[1] !== 4'b0000 || be_o[1] !== 4'b0000) begin
         bad++; $display("FAIL en_frozen: q=%b both=%b want 0000 0000", q_o[1], be_o[1]);
      end
      step(4'b1111, 4'b0000, 1'b1, 1'b0);
      total++;
      if (q_o[1] !== 4'b1111 || qb_o[1] !== 4'b0000) begin
         bad++; $display("FAIL en_release: q=%b qbar=%b want 1111 0000", q_o[1], qb_o[1]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (4) step(4'b0010, 4'b0010, 1'b1, 1'b0);
      total++;
      if (q_o[1] !== 4'b0010 || e2_o[1] !== 2'd1) begin
         bad++; $display("FAIL arst_setup: q=%b err=%0d want 0010 1", q_o[1], e2_o[1]);
      end
      repeat (2) step(4'b0001, 4'b0000, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (q_o[1] !== 4'h0 || qb_o[1] !== 4'hF || e2_o[1] !== 2'd0 || st_o[1] !== 1'b0 || be_o[1] !== 4'h0) begin
         bad++; $display("FAIL arst_immediate: q=%b qbar=%b err=%0d sticky=%b both=%b", q_o[1], qb_o[1], e2_o[1], st_o[1], be_o[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(4'b0001, 4'b0000, 1'b1, 1'b0);
         if (k >= 2) begin
            total++;
            if (q_o[0] !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
               bad++; $display("FAIL arst_refilter edge%0d: q=%b", k, q_o[0]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] cs, cr;
      logic [7:0] errv;
      int ch;
      do_reset();
      cs = '0; cr = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            ch = $urandom_range(0, 3);
            cs[ch] = 1'($urandom_range(0, 1));
            cr[ch] = 1'($urandom_range(0, 1));
         end
         step(cs, cr, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0));
         for (int i = 0; i < 5; i++) begin
            errv = (i == 4) ? e8_o : {6'b0, e2_o[i]};
            total++;
            if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || errv !== 8'(merr[i]) || st_o[i] !== mst[i]
                || be_o[i] !== {mf[i][3] == 2'b11, mf[i][2] == 2'b11, mf[i][1] == 2'b11, mf[i][0] == 2'b11}) begin
               bad++;
               $display("FAIL random n=%0d inst%0d: q=%b qbar=%b both=%b err=%0d sticky=%b want q=%b err=%0d sticky=%b",
                        n, i, q_o[i], qb_o[i], be_o[i], errv, st_o[i], mq[i], merr[i], mst[i]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; s_i = '0; r_i = '0; en_i = 1'b1; clr_i = 1'b0;
      test_reset();
      test_latency();
      test_glitch();
      test_modes();
      test_errors();
      test_enable();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
